// File: rtl/adder_seq_acc.sv
// adder_seq_acc
//   Multi-cycle adder/subtractor with a running accumulator. Two WIDTH-bit
//   operands are added CHUNK bits per clock, LSB chunk first, through a
//   single CHUNK-bit ripple slice. Subtraction is A + ~B + 1. With acc_en
//   set, operand A is taken from the last completed result.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous reset, active high
//   in_valid   in   1      operands and mode bits valid
//   in_ready   out  1      block can accept an operation (IDLE and not in reset)
//   a          in   WIDTH  operand A (ignored when acc_en=1)
//   b          in   WIDTH  operand B
//   sub        in   1      0: A+B, 1: A-B
//   acc_en     in   1      1: operand A := accumulator
//   out_valid  out  1      result valid (DONE state)
//   out_ready  in   1      consumer takes result
//   sum        out  WIDTH  result, registered
//   cout       out  1      carry out of MSB (sub: 1 = no borrow)
//   ovf        out  1      signed overflow
//   busy       out  1      high in CALC or DONE
module adder_seq_acc #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             acc_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             last;
    int unsigned      sh;
    logic [WIDTH-1:0] a_shr;
    logic [WIDTH-1:0] b_shr;
    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic [CHUNK-1:0] slice_sum;
    logic             ripple_c;
    logic             slice_cout;
    logic             slice_cmsb;
    logic [WIDTH-1:0] chunk_mask;
    logic [WIDTH-1:0] sum_nxt;

    assign accept = in_valid && in_ready;
    assign last   = (cnt == LAST);

    // Slice datapath: select chunk cnt of both operands, ripple-add it, and
    // merge the result into the running sum. sum_nxt is also what acc takes
    // on the last chunk, since sum itself is only updated at that same edge.
    always_comb begin
        sh         = 32'(cnt) * 32'(CHUNK);
        a_shr      = op_a >> sh;
        b_shr      = op_b >> sh;
        slice_a    = a_shr[CHUNK-1:0];
        slice_b    = b_shr[CHUNK-1:0];
        slice_sum  = '0;
        slice_cmsb = 1'b0;
        ripple_c   = carry;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            // carry into the top bit of the slice; on the last chunk this is
            // the carry into the operand MSB used for signed overflow
            if (i == CHUNK - 1)
                slice_cmsb = ripple_c;
            slice_sum[i] = slice_a[i] ^ slice_b[i] ^ ripple_c;
            ripple_c     = (slice_a[i] & slice_b[i]) |
                           (ripple_c & (slice_a[i] ^ slice_b[i]));
        end
        slice_cout = ripple_c;
        chunk_mask = WIDTH'({CHUNK{1'b1}}) << sh;
        sum_nxt    = (sum & ~chunk_mask) | (WIDTH'(slice_sum) << sh);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)                  state_nxt = CALC;
            CALC:    if (last)                    state_nxt = DONE;
            DONE:    if (out_valid && out_ready)  state_nxt = IDLE;
            default:                              state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // Operand, carry, counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            acc   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a  <= acc_en ? acc : a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                        sum   <= '0;
                    end
                end
                CALC: begin
                    sum   <= sum_nxt;
                    carry <= slice_cout;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        cout <= slice_cout;
                        ovf  <= slice_cmsb ^ slice_cout;
                        acc  <= sum_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
